// File: rtl/cap_pad_emulator.sv
// Behavioural capacitive-touch pad: follows the sensor's discharge enable and
// returns the pad voltage after a charge delay that grows with an emulated finger.
module cap_pad_emulator #(
    parameter int CW        = 15,
    parameter int JW        = 3,
    parameter int MIN_DISCH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          probe_oe,
    input  logic          touch,
    input  logic [CW-1:0] base_delay,
    input  logic [CW-1:0] touch_extra,
    input  logic          jitter_en,
    input  logic          clear_err,
    output logic          pad_level,
    output logic          charging,
    output logic [CW-1:0] last_delay,
    output logic [7:0]    charge_count,
    output logic          err_short,
    output logic [1:0]    state
);
    localparam int DW = $clog2(MIN_DISCH + 1);

    typedef enum logic [1:0] {IDLE, DISCHARGE, CHARGING, CHARGED} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] last_delay_q, last_delay_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          pad_q, pad_d;
    logic          charging_q, charging_d;
    logic          err_q, err_d;
    logic [CW+1:0] jit;
    logic [CW+1:0] sum;
    logic [CW-1:0] delay;

    generate
        if (JW > 0) begin : g_jit
            assign jit = jitter_en ? (CW+2)'(lfsr_q[JW-1:0]) : '0;
        end else begin : g_nojit
            assign jit = '0;
        end
    endgenerate

    // Wide sum so overflow saturates instead of wrapping; a zero delay still takes one cycle.
    assign sum = {2'b00, base_delay} + (touch ? {2'b00, touch_extra} : '0) + jit;
    always_comb begin
        delay = sum[CW-1:0];
        if (sum > {2'b00, {CW{1'b1}}}) delay = '1;
        else if (sum == '0)            delay = CW'(1);
    end

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        remaining_d  = remaining_q;
        last_delay_d = last_delay_q;
        count_d      = count_q;
        pad_d        = pad_q;
        charging_d   = 1'b0;
        err_d        = err_q;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (clear_err) err_d = 1'b0;

        case (state_q)
            IDLE, CHARGED: begin
                pad_d = 1'b1;
                if (probe_oe) begin
                    state_d = DISCHARGE;
                    pad_d   = 1'b0;
                    dcnt_d  = DW'(1);
                end
            end
            DISCHARGE: begin
                pad_d = 1'b0;
                if (probe_oe) begin
                    if (dcnt_q < DW'(MIN_DISCH)) dcnt_d = dcnt_q + DW'(1);
                end else if (dcnt_q >= DW'(MIN_DISCH)) begin
                    state_d      = CHARGING;
                    charging_d   = 1'b1;
                    last_delay_d = delay;
                    remaining_d  = delay;
                end else begin
                    state_d = CHARGED;
                    pad_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            CHARGING: begin
                remaining_d = remaining_q - CW'(1);
                if (probe_oe) begin
                    state_d = DISCHARGE;
                    pad_d   = 1'b0;
                    dcnt_d  = DW'(1);
                end else if (remaining_q == CW'(1)) begin
                    state_d = CHARGED;
                    pad_d   = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    charging_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            remaining_q  <= '0;
            last_delay_q <= '0;
            count_q      <= '0;
            lfsr_q       <= 8'h01;
            pad_q        <= 1'b1;
            charging_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            remaining_q  <= remaining_d;
            last_delay_q <= last_delay_d;
            count_q      <= count_d;
            lfsr_q       <= lfsr_d;
            pad_q        <= pad_d;
            charging_q   <= charging_d;
            err_q        <= err_d;
        end
    end

    assign pad_level    = pad_q;
    assign charging     = charging_q;
    assign last_delay   = last_delay_q;
    assign charge_count = count_q;
    assign err_short    = err_q;
    assign state        = state_q;
endmodule

// File: tb/tb_cap_pad_emulator.sv
// Directed bench for cap_pad_emulator: charge timing, touch, saturation, short
// discharge, abort, jitter range and asynchronous reset.
module tb_cap_pad_emulator;
    localparam int CW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          probe_oe = 1'b0;
    logic          touch = 1'b0;
    logic [CW-1:0] base_delay = '0;
    logic [CW-1:0] touch_extra = '0;
    logic          jitter_en = 1'b0;
    logic          clear_err = 1'b0;
    logic          pad_level;
    logic          charging;
    logic [CW-1:0] last_delay;
    logic [7:0]    charge_count;
    logic          err_short;
    logic [1:0]    state;

    int n_checks = 0;
    int n_pass   = 0;

    cap_pad_emulator dut (
        .clk(clk), .reset(reset), .probe_oe(probe_oe), .touch(touch),
        .base_delay(base_delay), .touch_extra(touch_extra), .jitter_en(jitter_en),
        .clear_err(clear_err), .pad_level(pad_level), .charging(charging),
        .last_delay(last_delay), .charge_count(charge_count), .err_short(err_short),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold probe_oe for 'hold' edges, release, then count cycles until pad rises.
    task automatic do_charge(input int hold, input int toggle_at, input int limit, output int rise);
        probe_oe = 1'b1;
        tick();
        check("pad_low_after_oe", pad_level, 1'b0);
        repeat (hold - 1) tick();
        probe_oe = 1'b0;
        tick();
        rise = -1;
        for (int k = 1; k <= limit; k++) begin
            if (k == toggle_at) touch = ~touch;
            tick();
            if (pad_level) begin
                rise = k;
                break;
            end
        end
        if (rise < 0) check("rise_timeout", 0, 1);
    endtask

    initial begin
        int r;
        int lo, hi;
        reset = 1'b0;
        repeat (3) tick();
        check("rst_pad", pad_level, 1'b1);
        check("rst_outs", {charging, err_short, charge_count, 17'(last_delay)}, 32'h0);
        check("rst_state", state, 2'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", {pad_level, charging, err_short, charge_count}, {1'b1, 1'b0, 1'b0, 8'd0});
        end

        base_delay = 15'd40;
        do_charge(10, 0, 100, r);
        check("rise_40", r, 40);
        check("ld_40", last_delay, 40);
        check("cnt_1", charge_count, 1);
        check("chg_done", charging, 0);

        touch = 1'b1; touch_extra = 15'd12;
        do_charge(10, 0, 100, r);
        check("rise_52", r, 52);
        check("ld_52", last_delay, 52);
        do_charge(10, 10, 100, r);
        check("rise_52_toggle", r, 52);
        check("cnt_3", charge_count, 3);

        touch = 1'b1;
        probe_oe = 1'b1;
        repeat (5) tick();
        probe_oe = 1'b0;
        tick();
        check("short_pad", pad_level, 1);
        check("short_err", err_short, 1);
        check("short_cnt", charge_count, 3);
        check("short_ld", last_delay, 52);
        repeat (3) tick();
        check("err_sticky", err_short, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("err_clear", err_short, 0);
        probe_oe = 1'b1;
        repeat (5) tick();
        probe_oe = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("err_set_prio", err_short, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;

        base_delay = 15'h7FF0; touch_extra = 15'h0100;
        probe_oe = 1'b1;
        repeat (10) tick();
        probe_oe = 1'b0;
        tick();
        check("ld_sat", last_delay, 15'h7FFF);
        check("sat_charging", charging, 1);
        base_delay = 15'd0; touch = 1'b0; touch_extra = 15'd0;
        do_charge(10, 0, 10, r);
        check("rise_zero", r, 1);
        check("ld_zero", last_delay, 1);
        check("cnt_after_sat", charge_count, 4);

        base_delay = 15'd40;
        probe_oe = 1'b1;
        repeat (10) tick();
        probe_oe = 1'b0;
        tick();
        repeat (20) tick();
        check("mid_pad", pad_level, 0);
        probe_oe = 1'b1;
        tick();
        check("abort_pad", pad_level, 0);
        check("abort_chg", charging, 0);
        check("abort_state", state, 2'd1);
        repeat (25) tick();
        check("abort_hold_pad", pad_level, 0);
        check("abort_cnt", charge_count, 4);
        probe_oe = 1'b0;
        tick();
        repeat (45) tick();
        check("post_abort_cnt", charge_count, 5);

        jitter_en = 1'b1;
        lo = 1000; hi = -1;
        for (int i = 0; i < 16; i++) begin
            do_charge(10, 0, 100, r);
            check("jit_range", (last_delay >= 40 && last_delay <= 47), 1);
            check("jit_rise", r, last_delay);
            if (int'(last_delay) < lo) lo = int'(last_delay);
            if (int'(last_delay) > hi) hi = int'(last_delay);
        end
        check("jit_varies", (hi > lo), 1);
        check("jit_cnt", charge_count, 21);

        jitter_en = 1'b0;
        probe_oe = 1'b1;
        repeat (10) tick();
        probe_oe = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("async_pad", pad_level, 1);
        check("async_outs", {charging, err_short, charge_count, 17'(last_delay)}, 32'h0);
        check("async_state", state, 2'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_idle", {pad_level, charging, charge_count}, {1'b1, 1'b0, 8'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cap_pad_emulator.md
Name: cap_pad_emulator

Overview:
- Behavioural pad model for on-chip loopback and bring-up. It is the far end of the capacitive-touch sense line.
- It watches the sensor's discharge enable and reproduces the pad voltage the sensor samples: low while discharged, then high after a charge delay.
- The charge delay lengthens when an emulated finger is present, and optional pseudo-random jitter can be added.
- Sits between the touch sensor's output-enable and its sense input in the test wrapper, so the sensor can be exercised without an analogue pad.

Parameters:
- CW, 15, width of delay values and internal charge counter.
- JW, 3, number of LFSR bits added as jitter (0 disables jitter).
- MIN_DISCH, 8, minimum discharge cycles for a valid (full) discharge.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- probe_oe  in  1  sensor discharge enable, same clock domain; 1 = sensor pulling pad low
- touch  in  1  emulated finger present
- base_delay  in  CW  untouched charge delay, in cycles
- touch_extra  in  CW  extra delay added when touched
- jitter_en  in  1  add LFSR jitter to the delay
- clear_err  in  1  clears err_short
- pad_level  out  1  emulated pad voltage, to the sensor's sense input
- charging  out  1  high while in CHARGING
- last_delay  out  CW  delay applied to the most recent charge
- charge_count  out  8  completed charges; wraps 255->0
- err_short  out  1  sticky: a discharge shorter than MIN_DISCH was seen

Behaviour:
- Reset (reset=0, async) values:
  - state IDLE, pad_level=1, charging=0, last_delay=0, charge_count=0, err_short=0
  - discharge counter dcnt=0, remaining=0, LFSR=8'h01
- All outputs are registered. Reset asserted mid-charge aborts immediately to the reset values.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle out of reset. Jitter value j = LFSR[JW-1:0] when jitter_en=1, else 0.
- States and transitions:
  - IDLE: pad_level=1. On an edge with probe_oe=1: go to DISCHARGE, set pad_level<=0 and dcnt<=1.
  - DISCHARGE: pad_level=0.
    - While probe_oe=1: dcnt increments, saturating at MIN_DISCH.
    - On an edge with probe_oe=0 and dcnt>=MIN_DISCH: compute D = base_delay + (touch ? touch_extra : 0) + j, sampled on that same edge. Compute in CW+2 bits, saturate to 2^CW-1, force 0 to 1. Then set last_delay<=D, remaining<=D, and go to CHARGING.
    - On an edge with probe_oe=0 and dcnt<MIN_DISCH (pad not fully discharged): set err_short<=1, pad_level<=1, go to CHARGED. charge_count is not incremented and last_delay is unchanged.
  - CHARGING: charging=1, pad_level=0.
    - Each edge decrements remaining.
    - On the edge where remaining==1: pad_level<=1, charge_count++, go to CHARGED.
    - As a result, pad_level first reads 1 exactly D cycles after the release edge.
    - probe_oe=1 during CHARGING: abort to DISCHARGE with dcnt<=1, no count increment. This takes priority over completion on the same edge.
  - CHARGED: pad_level=1. probe_oe=1 goes to DISCHARGE with dcnt<=1 and pad_level<=0. Otherwise stay.
- touch and the delay inputs are sampled only at the release edge. Changes during CHARGING do not affect the charge in progress.
- err_short:
  - Sticky until an edge with clear_err=1.
  - Set has priority over clear on the same edge.
- charge_count wraps silently.

Test Plan:
- Reset release, probe_oe=0 for 20 cycles -> pad_level=1, charge_count=0, err_short=0, charging=0 throughout.
- base_delay=40, touch=0, jitter_en=0; probe_oe high 10 cycles then low -> pad_level 0 from the cycle after probe_oe rose; first 1 exactly 40 cycles after the release edge; last_delay=40; charge_count=1.
- Same as above with touch=1, touch_extra=12 -> rise at 52 cycles, last_delay=52. Toggle touch mid-charge -> still 52.
- probe_oe high only 5 cycles (MIN_DISCH=8) -> pad_level=1 on the cycle after release, err_short=1, charge_count unchanged. clear_err pulse -> err_short=0.
- base_delay=7FF0, touch_extra=0100, touch=1 -> last_delay=7FFF (saturated). base_delay=0, touch=0 -> rise 1 cycle after release.
- Re-assert probe_oe 20 cycles into a 40-cycle charge -> pad_level stays 0, returns to DISCHARGE, no count increment. Then jitter_en=1 over 16 charges -> each last_delay lies in [base, base+7] and is not constant. Assert reset mid-charge -> pad_level=1 immediately, all counters 0.
